neander_seq_decod: RTL and testbench
====================================

Name: neander_seq_decod

Overview:
- Instruction-register, opcode-decode and timing-state generator for the Neander CPU.
- Sits directly upstream of the control unit. Supplies it with:
  - the 16-bit one-hot opcode vector (`codigo`);
  - the one-hot time state T0..T7.
- Consumes back from the control unit the RI load strobe and the return-to-T0 request.
- Latches the instruction byte from RDM, decodes its high nibble, advances the T-state counter each cycle, and freezes the machine on HLT.

Parameters:
- NT, 8, number of time states (one-hot width of sT); legal values 4..8.
- W, 8, data width of RI / eRDM.

Ports:
- clock  input  1  system clock, rising edge.
- ereset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- eRDM  input  W  byte from the memory data register.
- ecgRI  input  1  load RI from eRDM (control unit cgRI).
- eGOtoT0  input  1  return T-state to T0 (control unit GOtoT0).
- eena  input  1  global step enable; 0 = hold all state.
- sRI  output  W  current instruction register contents.
- sCodigo  output  16  one-hot decode of sRI[7:4]; bit k set when the opcode nibble is k.
- sT  output  NT  one-hot time state; bit i set in state Ti.
- sHalt  output  1  machine halted.

Behaviour:
- Reset (ereset=0 at the clock edge), regardless of any other input:
  - RI=0, so sCodigo=16'h0001 (NOP);
  - sT=T0 (bit 0 only);
  - sHalt=0.
- A reset mid-instruction or while halted returns to these values on the same edge.
- sCodigo is combinational from the RI register. It changes one cycle after the ecgRI edge, never in the same cycle.
- Opcode map, as decoded, one-hot: NOP 0, STA 1, LDA 2, ADD 3, OR 4, AND 5, NOT 6, JMP 8, JN 9, JZ A, HLT F.
  - Undefined nibbles (7, B-E) still raise their own bit; the control unit treats them as NOP.
  - sCodigo is never all-zero and never multi-hot.
- RI update, on a clock edge with ereset=1, eena=1, sHalt=0: if ecgRI=1, RI <= eRDM.
- T-state update, on a clock edge with ereset=1, eena=1, sHalt=0, in priority order:
  1. eGOtoT0=1 -> T0.
  2. Halt detect: current state T3 and sCodigo[15]=1 -> sHalt <= 1, T stays T3.
  3. Otherwise Ti -> Ti+1. T(NT-1) wraps to T0.
- ecgRI and eGOtoT0 in the same cycle: both take effect, RI loads and T returns to T0.
- eGOtoT0 in T3 with HLT decoded: eGOtoT0 wins and no halt occurs. The control unit must not request this.
- eena=0: RI, T and sHalt all hold. ecgRI and eGOtoT0 are ignored.
- sHalt=1 is sticky:
  - RI, T and sHalt hold;
  - ecgRI and eGOtoT0 are ignored;
  - only reset clears it.
- sT is always exactly one-hot. An illegal encoding cannot arise; the implementation holds T as a binary counter and decodes it.
- No combinational path from any input to sT, sRI or sHalt.
- sCodigo depends only on registered RI.

Decomposition:
- Shared package:
  - opcode nibble constants (OP_NOP..OP_HLT);
  - T-state index constants (T0..T7);
  - HLT_DETECT_T = 3.
- Sub-module dec4x16: purely combinational 4-to-16 one-hot decoder (nibble in, 16-bit out), reused for sCodigo.
- T counter and RI register live in the top module.

Test Plan:
- Reset then 8 cycles with eena=1 and no strobes -> sT steps 01,02,04,…,80 then wraps to 01; sCodigo=0001 throughout; sHalt=0.
- ecgRI=1 with eRDM=8'h3A in T2 -> next cycle sRI=3A and sCodigo=0008 (ADD); sT advances to T3 unaffected.
- eGOtoT0=1 in T5 -> next cycle sT=01. With ecgRI=1 and eRDM=8'h20 in that same cycle, additionally sRI=20 and sCodigo=0004.
- Load eRDM=8'hF0 in T2 -> in T3 sCodigo=8000; next edge sHalt=1 and sT stays 08. Further ecgRI, eGOtoT0 and 10 cycles of clocks change nothing. ereset=0 for one edge -> sHalt=0, sT=01, sRI=00.
- eena=0 for 3 cycles while in T4 with ecgRI=1 and eRDM=8'h55 -> sT stays 10 and sRI unchanged. eena=1 -> sT=20 next cycle.
- Load each nibble 0..F in turn (eRDM=k<<4) -> sCodigo equals 1<<k, exactly one bit set. HLT only halts when the machine reaches T3.

Source files
------------

// File: rtl/neander_seq_decod_pkg.sv
// Shared constants for the Neander instruction register, decoder and T-state generator.
package neander_seq_decod_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int T6 = 6;
  localparam int T7 = 7;

  localparam int HLT_DETECT_T = T3;

endpackage

// File: rtl/neander_seq_decod_dec4x16.sv
// Combinational 4-to-16 one-hot decoder.
module dec4x16
  import neander_seq_decod_pkg::*;
(
  input  logic [3:0]  nib,
  output logic [15:0] onehot
);

  for (genvar k = 0; k < 16; k++) begin : g_bit
    assign onehot[k] = (nib == 4'(k));
  end

endmodule

// File: rtl/neander_seq_decod.sv
// Neander instruction register, opcode decode and one-hot T-state generator with HLT freeze.
module neander_seq_decod
  import neander_seq_decod_pkg::*;
#(
  parameter int NT = 8,
  parameter int W  = 8
) (
  input  logic          clock,
  input  logic          ereset,
  input  logic [W-1:0]  eRDM,
  input  logic          ecgRI,
  input  logic          eGOtoT0,
  input  logic          eena,
  output logic [W-1:0]  sRI,
  output logic [15:0]   sCodigo,
  output logic [NT-1:0] sT,
  output logic          sHalt
);

  localparam int TW = (NT > 4) ? 3 : 2;

  logic [W-1:0]  ri_q, ri_d;
  logic [TW-1:0] t_q, t_d;
  logic          halt_q, halt_d;
  logic          step;
  logic          hlt_here;

  assign step     = eena & ~halt_q;
  assign hlt_here = (t_q == TW'(HLT_DETECT_T)) && sCodigo[OP_HLT];

  always_comb begin
    ri_d   = ri_q;
    t_d    = t_q;
    halt_d = halt_q;
    if (step) begin
      if (ecgRI) ri_d = eRDM;
      // GOtoT0 outranks halt detection so the control unit can always restart the cycle.
      if (eGOtoT0)                  t_d    = '0;
      else if (hlt_here)            halt_d = 1'b1;
      else if (t_q == TW'(NT - 1))  t_d    = '0;
      else                          t_d    = t_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!ereset) begin
      ri_q   <= '0;
      t_q    <= '0;
      halt_q <= 1'b0;
    end else begin
      ri_q   <= ri_d;
      t_q    <= t_d;
      halt_q <= halt_d;
    end
  end

  for (genvar i = 0; i < NT; i++) begin : g_t
    assign sT[i] = (t_q == TW'(i));
  end

  dec4x16 u_dec (
    .nib    (ri_q[W-1 -: 4]),
    .onehot (sCodigo)
  );

  assign sRI   = ri_q;
  assign sHalt = halt_q;

endmodule

// File: tb/tb_neander_seq_decod.sv
// Scoreboard bench: each cycle pushes its expected state, pops and compares after the edge.
module tb_neander_seq_decod;

  logic        clock = 1'b0;
  logic        ereset = 1'b0;
  logic [7:0]  eRDM = '0;
  logic        ecgRI = 1'b0;
  logic        eGOtoT0 = 1'b0;
  logic        eena = 1'b0;
  logic [7:0]  sRI;
  logic [15:0] sCodigo;
  logic [7:0]  sT;
  logic        sHalt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  ri;
    logic [15:0] cod;
    logic [7:0]  t;
    logic        halt;
  } obs_t;

  obs_t sb[$];
  obs_t e, o;

  neander_seq_decod #(.NT(8), .W(8)) dut (
    .clock   (clock),
    .ereset  (ereset),
    .eRDM    (eRDM),
    .ecgRI   (ecgRI),
    .eGOtoT0 (eGOtoT0),
    .eena    (eena),
    .sRI     (sRI),
    .sCodigo (sCodigo),
    .sT      (sT),
    .sHalt   (sHalt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got timeout, wanted finish");
    $fatal(1);
  end

  function automatic obs_t mk(input logic [7:0] ri, input logic [7:0] t, input logic halt);
    obs_t r;
    r.ri   = ri;
    r.cod  = 16'h0001 << ri[7:4];
    r.t    = t;
    r.halt = halt;
    return r;
  endfunction

  function automatic obs_t cur();
    obs_t r;
    r.ri = sRI; r.cod = sCodigo; r.t = sT; r.halt = sHalt;
    return r;
  endfunction

  // Drive one cycle of inputs, queue its expected post-edge state, then step past the edge.
  task automatic cyc(input logic rst, input logic ena, input logic cg, input logic go,
                     input logic [7:0] rdm, input obs_t exp);
    ereset = rst; eena = ena; ecgRI = cg; eGOtoT0 = go; eRDM = rdm;
    sb.push_back(exp);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, mk(8'h00, 8'h01, 1'b0));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset: got %h wanted %h", o, e); end
    if (sCodigo !== 16'h0001) begin errors++; $display("FAIL reset_nop: got %h wanted 0001", sCodigo); end
    checks++;
  endtask

  task automatic test_tstep();
    logic [7:0] t;
    t = 8'h01;
    for (int i = 0; i < 8; i++) begin
      t = (t == 8'h80) ? 8'h01 : (t << 1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, mk(8'h00, t, 1'b0));
      e = sb.pop_front(); o = cur(); checks++;
      if (o !== e) begin errors++; $display("FAIL tstep%0d: got %h wanted %h", i, o, e); end
    end
  endtask

  task automatic test_load_add();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h02, 1'b0));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h04, 1'b0));
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h3A, mk(8'h3A, 8'h08, 1'b0));
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      if (i == 2) begin
        o = cur(); checks++;
        if (o !== e) begin errors++; $display("FAIL load_add: got %h wanted %h", o, e); end
        checks++;
        if (sCodigo !== 16'h0008) begin errors++; $display("FAIL add_code: got %h wanted 0008", sCodigo); end
      end
    end
  endtask

  task automatic test_goto();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h3A, 8'h10, 1'b0));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL goto_t4: got %h wanted %h", o, e); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h3A, 8'h20, 1'b0));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL goto_t5: got %h wanted %h", o, e); end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, mk(8'h20, 8'h01, 1'b0));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL goto_load: got %h wanted %h", o, e); end
    checks++;
    if (sCodigo !== 16'h0004) begin errors++; $display("FAIL lda_code: got %h wanted 0004", sCodigo); end
  endtask

  task automatic test_halt();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h01, 1'b0));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h02, 1'b0));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h04, 1'b0));
    repeat (3) void'(sb.pop_front());
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, mk(8'hF0, 8'h08, 1'b0));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL halt_t3: got %h wanted %h", o, e); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'hF0, 8'h08, 1'b1));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL halt_set: got %h wanted %h", o, e); end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h11, mk(8'hF0, 8'h08, 1'b1));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL halt_strobes: got %h wanted %h", o, e); end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, i[0], i[1], 8'(i * 8'h13), mk(8'hF0, 8'h08, 1'b1));
      e = sb.pop_front(); o = cur(); checks++;
      if (o !== e) begin errors++; $display("FAIL halt_hold%0d: got %h wanted %h", i, o, e); end
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h77, mk(8'h00, 8'h01, 1'b0));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL halt_reset: got %h wanted %h", o, e); end
  endtask

  task automatic test_eena();
    logic [7:0] t;
    t = 8'h01;
    for (int i = 0; i < 4; i++) begin
      t = t << 1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, t, 1'b0));
      void'(sb.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h55, mk(8'h00, 8'h10, 1'b0));
      e = sb.pop_front(); o = cur(); checks++;
      if (o !== e) begin errors++; $display("FAIL eena_hold%0d: got %h wanted %h", i, o, e); end
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, mk(8'h00, 8'h20, 1'b0));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL eena_resume: got %h wanted %h", o, e); end
  endtask

  task automatic test_nibbles();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h01, 1'b0));
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h02, 1'b0));
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h04, 1'b0));
      repeat (3) void'(sb.pop_front());
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'(k << 4) | 8'h05, mk(8'(k << 4) | 8'h05, 8'h08, 1'b0));
      e = sb.pop_front(); checks++;
      if (sCodigo !== (16'h0001 << k) || $countones(sCodigo) != 1 || sRI !== e.ri) begin
        errors++; $display("FAIL nib%0d_code: got %h wanted %h", k, sCodigo, 16'h0001 << k);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00,
          (k == 15) ? mk(8'hF5, 8'h08, 1'b1) : mk(8'(k << 4) | 8'h05, 8'h10, 1'b0));
      e = sb.pop_front(); o = cur(); checks++;
      if (o !== e) begin errors++; $display("FAIL nib%0d_next: got %h wanted %h", k, o, e); end
    end
  endtask

  task automatic test_hlt_early();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h01, 1'b0));
    void'(sb.pop_front());
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, mk(8'hF0, 8'h02, 1'b0));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'hF0, 8'h04, 1'b0));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'hF0, 8'h08, 1'b0));
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      if (i == 2) begin
        o = cur(); checks++;
        if (o !== e) begin errors++; $display("FAIL hlt_early: got %h wanted %h", o, e); end
      end
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, mk(8'hF0, 8'h01, 1'b0));
    e = sb.pop_front(); o = cur(); checks++;
    if (o !== e) begin errors++; $display("FAIL hlt_goto_wins: got %h wanted %h", o, e); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 8'h01, 1'b0));
    void'(sb.pop_front());
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'(i * 8'h21), mk(8'(i * 8'h21), 8'h01 << i, 1'b0));
      e = sb.pop_front(); o = cur(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b%0d: got %h wanted %h", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_tstep();
    test_load_add();
    test_goto();
    test_halt();
    test_eena();
    test_nibbles();
    test_hlt_early();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left wanted 0", sb.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
